// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, RAM handshake state, memory arbiter FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Status reported by the RAM model for the access currently being driven.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter sequencing: one access state and one response state per requester.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACC_I  = 3'd1,
        ACC_D  = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch (imem) and data (dmem); data wins, starvation-bounded.
// Latency: hit two cycles after an IDLE grant when RAM answers ACCESS at once; +1 per BUSY cycle.
// Backpressure: requesters hold iREN/dREN/dWEN until their one-cycle hit; RAM stalls via ramstate BUSY.
//
// Ports:
//   CLK, RST                         clock, synchronous active-high reset
//   iREN, iaddr / iload, ihit        instruction read request and registered completion
//   dREN, dWEN, daddr, dstore        data request (dWEN wins if both set)
//   dload, dhit                      registered data read value and completion pulse
//   ramREN, ramWEN, ramaddr,         RAM command, decoded from state and latched request
//   ramstore / ramload, ramstate     RAM data and handshake status
//   timeout_err                      sticky flag: some access timed out and was retried
//   busy                             arbiter not in IDLE
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        timeout_err,
    output logic        busy
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t    state;
    arb_state_t    next_state;
    logic [SW-1:0] starve_cnt;
    logic [WW-1:0] wait_cnt;
    word_t         addr_q;
    word_t         store_q;
    logic          wen_q;

    logic          dgrant;
    logic          wait_done;
    logic          in_access;

    // Data wins unless the instruction side has already lost STARVE_LIMIT grants in a row.
    assign dgrant    = (dREN | dWEN) && !(iREN && (starve_cnt == SW'(STARVE_LIMIT)));
    assign wait_done = (wait_cnt == WW'(TIMEOUT - 1));
    assign in_access = (state == ACC_I) || (state == ACC_D);
    assign busy      = (state != IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (dgrant) begin
                    next_state = ACC_D;
                end else if (iREN) begin
                    next_state = ACC_I;
                end
            end
            ACC_I, ACC_D: begin
                if (ramstate == ACCESS) begin
                    next_state = (state == ACC_I) ? RESP_I : RESP_D;
                end else if ((ramstate == ERROR) || wait_done) begin
                    // Abort: the still-held request is re-arbitrated from IDLE.
                    next_state = IDLE;
                end
            end
            RESP_I, RESP_D: next_state = IDLE;
            default:        next_state = IDLE;
        endcase
    end

    // RAM command is a pure decode so it drops the same cycle the state leaves ACC_x.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            ACC_I: begin
                ramREN  = 1'b1;
                ramaddr = addr_q;
            end
            ACC_D: begin
                ramREN   = !wen_q;
                ramWEN   = wen_q;
                ramaddr  = addr_q;
                ramstore = store_q;
            end
            default: begin
                ramREN   = 1'b0;
                ramWEN   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            wait_cnt    <= '0;
            addr_q      <= '0;
            store_q     <= '0;
            wen_q       <= 1'b0;
            ihit        <= 1'b0;
            dhit        <= 1'b0;
            iload       <= '0;
            dload       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= next_state;
            ihit  <= (next_state == RESP_I);
            dhit  <= (next_state == RESP_D);

            // Grant: capture the winner's request so mid-access input changes are ignored.
            if (state == IDLE) begin
                if (next_state == ACC_D) begin
                    addr_q  <= daddr;
                    store_q <= dstore;
                    wen_q   <= dWEN;
                    if (!iREN) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
                        starve_cnt <= starve_cnt + SW'(1);
                    end
                end else if (next_state == ACC_I) begin
                    addr_q     <= iaddr;
                    store_q    <= '0;
                    wen_q      <= 1'b0;
                    starve_cnt <= '0;
                end
            end

            if (in_access) begin
                if (next_state != state) begin
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + WW'(1);
                end

                if (ramstate == ACCESS) begin
                    if (state == ACC_I) begin
                        iload <= ramload;
                    end else if (!wen_q) begin
                        dload <= ramload;
                    end
                end else if ((ramstate != ERROR) && wait_done) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized traffic against a transaction model.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: the bench plays both requesters and the RAM (random BUSY/ERROR stalls).
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int LIMIT = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        ihit, dhit, ramREN, ramWEN, timeout_err, busy;
    ramstate_t   ramstate;

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(64)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dhit(dhit),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
    endtask

    // Random-phase model state
    word_t       ram_mem [16];
    word_t       gold    [16];
    logic        i_pend, d_pend, d_wr, d_both;
    logic [31:0] i_addr, d_addr, d_data;
    int          own;        // 0 none, 1 instruction, 2 data
    int          starve;
    logic        exp_ih, exp_dh, prev_en, en, err;
    int          acc_cnt, busy_n, done_cnt, count, k;
    logic        gseq [10];

    initial begin
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
        cyc(); cyc();
        chk("rst_ihit", ihit, 0);       chk("rst_dhit", dhit, 0);
        chk("rst_iload", iload, 0);     chk("rst_dload", dload, 0);
        chk("rst_ramREN", ramREN, 0);   chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0); chk("rst_ramstore", ramstore, 0);
        chk("rst_tmo", timeout_err, 0); chk("rst_busy", busy, 0);

        // Reset in the middle of a data write: dropped, no hit, no retry.
        RST = 0; dWEN = 1; daddr = 32'h40; dstore = 32'h1234_5678; ramstate = BUSY;
        cyc();
        chk("t1_wen", ramWEN, 1); chk("t1_addr", ramaddr, 32'h40); chk("t1_store", ramstore, 32'h1234_5678);
        RST = 1; dWEN = 0;
        cyc();
        chk("t1_wen_drop", ramWEN, 0); chk("t1_busy", busy, 0); chk("t1_dhit", dhit, 0);
        RST = 0;
        cyc();
        chk("t1_noretry", ramWEN, 0); chk("t1_dhit2", dhit, 0); chk("t1_busy2", busy, 0);

        // Instruction fetch with two BUSY cycles.
        iREN = 1; iaddr = 32'h100; ramstate = BUSY;
        cyc(); chk("t2_ren0", ramREN, 1); chk("t2_addr", ramaddr, 32'h100); chk("t2_ihit0", ihit, 0);
        cyc(); chk("t2_ren1", ramREN, 1); chk("t2_ihit1", ihit, 0);
        cyc(); chk("t2_ren2", ramREN, 1);
        ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
        cyc(); chk("t2_ihit", ihit, 1); chk("t2_iload", iload, 32'hDEAD_BEEF); chk("t2_ren_off", ramREN, 0);
        iREN = 0; ramstate = FREE;
        cyc(); chk("t2_ihit_pulse", ihit, 0); chk("t2_idle", busy, 0);

        // Simultaneous requests: data first.
        iREN = 1; iaddr = 32'h200; dREN = 1; daddr = 32'h300; ramstate = ACCESS; ramload = 32'hAAAA_0001;
        cyc(); chk("t3_daddr", ramaddr, 32'h300); chk("t3_dren", ramREN, 1);
        cyc(); chk("t3_dhit", dhit, 1); chk("t3_dload", dload, 32'hAAAA_0001); chk("t3_ihit0", ihit, 0);
        dREN = 0; ramload = 32'hBBBB_0002;
        cyc(); chk("t3_idle", busy, 0); chk("t3_ren_idle", ramREN, 0);
        cyc(); chk("t3_iaddr", ramaddr, 32'h200); chk("t3_iren", ramREN, 1);
        cyc(); chk("t3_ihit", ihit, 1); chk("t3_iload", iload, 32'hBBBB_0002);
        iREN = 0;
        cyc();

        // Starvation bound: D,D,D,D,I repeating.
        dWEN = 1; daddr = 32'h10; dstore = 32'h5; iREN = 1; iaddr = 32'h20; ramstate = ACCESS;
        k = 0;
        for (int c = 0; c < 30; c++) begin
            cyc();
            if ((ramREN || ramWEN) && k < 10) begin
                gseq[k] = ramWEN;
                k++;
            end
        end
        dWEN = 0; iREN = 0;
        chk("t4_grants", k, 10);
        for (int j = 0; j < 10; j++) chk($sformatf("t4_grant%0d_is_d", j), gseq[j], (j % 5) != 4);
        cyc(); cyc(); cyc();

        // Stuck BUSY: 64 access cycles, abort, sticky error, re-grant.
        iREN = 1; iaddr = 32'h44; ramstate = BUSY; count = 0;
        for (int c = 0; c < 80; c++) begin
            cyc();
            if (ramREN) count++;
            else break;
        end
        chk("t5_acc_cycles", count, 64); chk("t5_en_drop", ramREN, 0);
        chk("t5_tmo", timeout_err, 1); chk("t5_busy", busy, 0); chk("t5_ihit", ihit, 0);
        cyc(); chk("t5_regrant", ramREN, 1); chk("t5_addr", ramaddr, 32'h44);
        ramstate = ACCESS; ramload = 32'h77;
        cyc(); chk("t5_ihit2", ihit, 1); chk("t5_iload", iload, 32'h77); chk("t5_sticky", timeout_err, 1);
        iREN = 0; ramstate = FREE;
        cyc();

        // ERROR on first access cycle, then a clean retry.
        RST = 1; cyc(); RST = 0;
        chk("t6_tmo_clr", timeout_err, 0);
        dREN = 1; daddr = 32'h50; ramstate = ERROR;
        cyc(); chk("t6_ren", ramREN, 1);
        cyc(); chk("t6_abort", ramREN, 0); chk("t6_nohit", dhit, 0); chk("t6_idle", busy, 0);
        ramstate = ACCESS; ramload = 32'hCAFE;
        cyc(); chk("t6_reissue", ramREN, 1); chk("t6_addr", ramaddr, 32'h50);
        cyc(); chk("t6_dhit", dhit, 1); chk("t6_dload", dload, 32'hCAFE);
        dREN = 0; ramstate = FREE;
        cyc(); chk("t6_tmo", timeout_err, 0);

        // Randomized traffic against a transaction-level model.
        for (int j = 0; j < 16; j++) begin
            ram_mem[j] = $urandom;
            gold[j] = ram_mem[j];
        end
        i_pend = 0; d_pend = 0; d_wr = 0; d_both = 0; i_addr = 0; d_addr = 0; d_data = 0;
        own = 0; starve = 0; exp_ih = 0; exp_dh = 0; prev_en = 0; acc_cnt = 0; busy_n = 0;
        err = 0; done_cnt = 0;
        for (int c = 0; c < 3150; c++) begin
            cyc();
            en = ramREN | ramWEN;
            chk("rnd_ihit", ihit, exp_ih);
            chk("rnd_dhit", dhit, exp_dh);
            chk("rnd_en_excl", ramREN & ramWEN, 0);
            if (exp_ih) begin
                chk("rnd_iload", iload, gold[i_addr[5:2]]);
                i_pend = 0; done_cnt++;
            end
            if (exp_dh) begin
                if (d_wr) gold[d_addr[5:2]] = d_data;
                else chk("rnd_dload", dload, gold[d_addr[5:2]]);
                d_pend = 0; done_cnt++;
            end

            // New grant: apply the priority rule to the requests that were pending.
            if (en && !prev_en) begin
                if (d_pend && !(i_pend && starve == LIMIT)) begin
                    own = 2;
                    starve = i_pend ? ((starve == LIMIT) ? LIMIT : starve + 1) : 0;
                end else begin
                    own = i_pend ? 1 : 0;
                    starve = 0;
                end
            end
            if (en) begin
                chk("rnd_owner", own != 0, 1);
                if (own == 2) begin
                    chk("rnd_d_op", ramWEN, d_wr);
                    chk("rnd_d_addr", ramaddr, d_addr);
                    if (d_wr) chk("rnd_d_store", ramstore, d_data);
                end else begin
                    chk("rnd_i_op", ramREN, 1);
                    chk("rnd_i_addr", ramaddr, i_addr);
                end
            end

            // RAM model.
            exp_ih = 0; exp_dh = 0;
            if (en) begin
                if (acc_cnt == 0) begin
                    busy_n = $urandom_range(0, 3);
                    err = ($urandom_range(0, 7) == 0);
                end
                if (acc_cnt < busy_n) begin
                    ramstate = BUSY; ramload = $urandom; acc_cnt++;
                end else if (err) begin
                    ramstate = ERROR; ramload = $urandom; acc_cnt = 0; own = 0;
                end else begin
                    ramstate = ACCESS;
                    if (ramWEN) begin
                        ram_mem[ramaddr[5:2]] = ramstore;
                        ramload = $urandom;
                    end else begin
                        ramload = ram_mem[ramaddr[5:2]];
                    end
                    exp_ih = (own == 1); exp_dh = (own == 2); acc_cnt = 0;
                end
            end else begin
                ramstate = FREE; ramload = $urandom; acc_cnt = 0;
            end

            // Requesters.
            if (c < 3000) begin
                if (!i_pend && $urandom_range(0, 2) == 0) begin
                    i_pend = 1; i_addr = {26'd0, 4'($urandom), 2'b00};
                end
                if (!d_pend && $urandom_range(0, 2) == 0) begin
                    d_pend = 1; d_wr = 1'($urandom); d_both = 1'($urandom);
                    d_addr = {26'd0, 4'($urandom), 2'b00}; d_data = $urandom;
                end
            end
            iREN = i_pend; iaddr = i_addr;
            dWEN = d_pend && d_wr;
            dREN = d_pend && (!d_wr || d_both);
            daddr = d_addr; dstore = d_data;
            prev_en = en;
        end
        chk("rnd_drain_i", i_pend, 0);
        chk("rnd_drain_d", d_pend, 0);
        chk("rnd_progress", done_cnt >= 200, 1);
        chk("rnd_no_tmo", timeout_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
